// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP-RISC single-cycle core: opcodes, functs,
// ALU operation encoding and the decoded control bundle.
package kgp_risc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } aluop_t;

  typedef struct packed {
    logic regwrite;
    logic regdst;
    logic alusrc;
    logic memwrite;
    logic memtoreg;
    logic branch;
    logic bne;
    logic jump;
    logic halt;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/kgp_risc_datapath.sv
// Single-cycle datapath: PC, ALU, next-PC selection and the three storage leaves.
module kgp_risc_datapath
  import kgp_risc_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  ctrl_t       ctrl,
  input  aluop_t      aluop,
  output logic [5:0]  op,
  output logic [5:0]  fn,
  output logic [31:0] writedata
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] pc_reg, pc_next, pc_plus4, br_target, j_target;
  logic [31:0] instr, rs_data, rt_data, imm_ext, alu_b, alu_result;
  logic [31:0] mem_rdata, wb_data;
  logic [4:0]  wr_addr;
  logic        take_branch;

  kgp_risc_imem #(.WORDS(IMEM_WORDS)) imem (
    .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
    .raddr(pc_reg[IAW+1:2]), .rdata(instr)
  );

  kgp_risc_rbank rbank (
    .clk(clk), .reset(reset), .we(ctrl.regwrite),
    .ra1(instr[25:21]), .ra2(instr[20:16]), .wa(wr_addr), .wd(wb_data),
    .rd1(rs_data), .rd2(rt_data)
  );

  kgp_risc_dmem #(.WORDS(DMEM_WORDS)) dmem (
    .clk(clk), .reset(reset), .we(ctrl.memwrite),
    .addr(alu_result[DAW+1:2]), .wdata(rt_data), .rdata(mem_rdata)
  );

  assign op        = instr[31:26];
  assign fn        = instr[5:0];
  assign writedata = rt_data;
  assign imm_ext   = sext16(instr[15:0]);
  assign alu_b     = ctrl.alusrc ? imm_ext : rt_data;
  assign wr_addr   = ctrl.regdst ? instr[15:11] : instr[20:16];
  assign wb_data   = ctrl.memtoreg ? mem_rdata : alu_result;

  // Shifts take rt and the shamt field, not the rs/alu_b pair.
  always_comb begin
    alu_result = '0;
    case (aluop)
      ALU_ADD: alu_result = rs_data + alu_b;
      ALU_SUB: alu_result = rs_data - alu_b;
      ALU_AND: alu_result = rs_data & alu_b;
      ALU_OR:  alu_result = rs_data | alu_b;
      ALU_XOR: alu_result = rs_data ^ alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(rs_data) < $signed(alu_b)};
      ALU_SLL: alu_result = rt_data << instr[10:6];
      ALU_SRL: alu_result = rt_data >> instr[10:6];
      default: alu_result = '0;
    endcase
  end

  assign pc_plus4    = pc_reg + 32'd4;
  assign br_target   = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign j_target    = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign take_branch = ctrl.branch & ((rs_data == rt_data) ^ ctrl.bne);

  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.halt)       pc_next = pc_reg;
    else if (ctrl.jump)  pc_next = j_target;
    else if (take_branch) pc_next = br_target;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_reg <= '0;
    else       pc_reg <= pc_next;
  end

endmodule

// File: rtl/kgp_risc_dmem.sv
// Data memory: asynchronous read, write on the clock edge; contents survive reset.
module kgp_risc_dmem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] dmem [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we && !reset) dmem[addr] <= wdata;
  end

  assign rdata = dmem[addr];

endmodule

// File: rtl/kgp_risc_imem.sv
// Instruction memory: asynchronous read; the write port exists only so the
// array has a driver and is normally tied off (programs are loaded by backdoor).
module kgp_risc_imem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] imem [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) imem[waddr] <= wdata;
  end

  assign rdata = imem[raddr];

endmodule

// File: rtl/kgp_risc_rbank.sv
// 32 x 32 register file: two asynchronous read ports, one write port, $0 hardwired to zero.
module kgp_risc_rbank (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regfile [0:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regfile[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regfile[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regfile[ra2];

endmodule

// File: rtl/kgp_risc_core.sv
// KGP-RISC single-cycle core top: instruction decode plus the datapath instance.
// Define KGP_RISC_HALT_EN to make opcode 0x3F freeze the PC until reset.
module kgp_risc_core
  import kgp_risc_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writedata
);

  logic [5:0] op, fn;
  ctrl_t      ctrl;
  aluop_t     aluop;

  // Anything not decoded below leaves ctrl all-zero, i.e. a NOP with PC+4.
  always_comb begin
    ctrl  = '0;
    aluop = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        case (fn)
          FN_ADD:  aluop = ALU_ADD;
          FN_SUB:  aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_XOR:  aluop = ALU_XOR;
          FN_SLT:  aluop = ALU_SLT;
          FN_SLL:  aluop = ALU_SLL;
          FN_SRL:  aluop = ALU_SRL;
          default: ctrl.regwrite = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      OP_SW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      OP_BEQ: ctrl.branch = 1'b1;
      OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.bne    = 1'b1;
      end
      OP_J: ctrl.jump = 1'b1;
`ifdef KGP_RISC_HALT_EN
      OP_HALT: ctrl.halt = 1'b1;
`endif
      default: ;
    endcase
  end

  kgp_risc_datapath #(
    .IMEM_WORDS(IMEM_WORDS),
    .DMEM_WORDS(DMEM_WORDS)
  ) dpath (
    .clk(clk), .reset(reset), .ctrl(ctrl), .aluop(aluop),
    .op(op), .fn(fn), .writedata(writedata)
  );

endmodule

// File: tb/tb_kgp_risc_core.sv
// Directed bench for kgp_risc_core: programs and data loaded through hierarchy,
// results inspected through hierarchy and the writedata port.
module tb_kgp_risc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] writedata;
  int          checks = 0;
  int          errors = 0;

  kgp_risc_core dut (.clk(clk), .reset(reset), .writedata(writedata));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.dpath.imem.imem[i] = 32'd0;
  endtask

  initial begin
    logic [31:0] acc;
    int cyc;

    // 1: reset with empty imem, then free-run NOPs
    @(negedge clk);
    reset = 1'b1;
    clear_imem();
    step(2);
    check("rst_pc_held", dut.dpath.pc_reg, 32'd0);
    reset = 1'b0;
    acc = 32'd0;
    for (int i = 0; i < 32; i++) acc = acc | dut.dpath.rbank.regfile[i];
    check("rst_regs", acc, 32'd0);
    check("rst_pc", dut.dpath.pc_reg, 32'd0);
    check("rst_wdata", writedata, 32'd0);
    step(1);
    check("pc_plus4", dut.dpath.pc_reg, 32'd4);
    step(3);
    check("pc_16", dut.dpath.pc_reg, 32'd16);

    // 2: arithmetic / logic / shifts
    reset = 1'b1;
    clear_imem();
    dut.dpath.imem.imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    dut.dpath.imem.imem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    dut.dpath.imem.imem[2]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    dut.dpath.imem.imem[3]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);
    dut.dpath.imem.imem[4]  = enc_r(5'd4, 5'd1, 5'd7, 5'd0, 6'h2A);
    dut.dpath.imem.imem[5]  = enc_r(5'd0, 5'd1, 5'd8, 5'd4, 6'h00);
    dut.dpath.imem.imem[6]  = enc_r(5'd0, 5'd4, 5'd9, 5'd28, 6'h02);
    dut.dpath.imem.imem[7]  = enc_r(5'd1, 5'd2, 5'd10, 5'd0, 6'h24);
    dut.dpath.imem.imem[8]  = enc_r(5'd1, 5'd2, 5'd11, 5'd0, 6'h25);
    dut.dpath.imem.imem[9]  = enc_r(5'd1, 5'd2, 5'd12, 5'd0, 6'h26);
    dut.dpath.imem.imem[10] = enc_r(5'd1, 5'd4, 5'd13, 5'd0, 6'h2A);
    dut.dpath.imem.imem[11] = enc_i(6'h08, 5'd0, 5'd14, 16'hFFFD);
    step(2);
    reset = 1'b0;
    step(4);
    check("add_r3", dut.dpath.rbank.regfile[3], 32'd12);
    check("sub_r4", dut.dpath.rbank.regfile[4], 32'hFFFF_FFFE);
    step(8);
    check("slt_neg", dut.dpath.rbank.regfile[7], 32'd1);
    check("sll_r8", dut.dpath.rbank.regfile[8], 32'h0000_0050);
    check("srl_r9", dut.dpath.rbank.regfile[9], 32'h0000_000F);
    check("and_r10", dut.dpath.rbank.regfile[10], 32'd5);
    check("or_r11", dut.dpath.rbank.regfile[11], 32'd7);
    check("xor_r12", dut.dpath.rbank.regfile[12], 32'd2);
    check("slt_pos", dut.dpath.rbank.regfile[13], 32'd0);
    check("addi_neg", dut.dpath.rbank.regfile[14], 32'hFFFF_FFFD);

    // 3: store/load, address wrap, negative offset, reset overriding a store
    reset = 1'b1;
    clear_imem();
    dut.dpath.dmem.dmem[1] = 32'd0;
    dut.dpath.dmem.dmem[7] = 32'd0;
    dut.dpath.dmem.dmem[9] = 32'hDEAD_BEEF;
    dut.dpath.imem.imem[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
    dut.dpath.imem.imem[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'd28);
    dut.dpath.imem.imem[2] = enc_i(6'h23, 5'd0, 5'd5, 16'd28);
    dut.dpath.imem.imem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0404);
    dut.dpath.imem.imem[4] = enc_i(6'h08, 5'd0, 5'd12, 16'd40);
    dut.dpath.imem.imem[5] = enc_i(6'h23, 5'd12, 5'd13, 16'hFFF4);
    dut.dpath.imem.imem[6] = enc_i(6'h2B, 5'd0, 5'd3, 16'd36);
    step(2);
    reset = 1'b0;
    step(1);
    check("sw_wdata", writedata, 32'd12);
    step(1);
    check("sw_dmem7", dut.dpath.dmem.dmem[7], 32'd12);
    step(1);
    check("lw_r5", dut.dpath.rbank.regfile[5], 32'd12);
    step(3);
    check("sw_wrap", dut.dpath.dmem.dmem[1], 32'd12);
    check("lw_negoff", dut.dpath.rbank.regfile[13], 32'd12);
    check("pc_pre_rst", dut.dpath.pc_reg, 32'h18);
    reset = 1'b1;
    step(1);
    check("rst_mid_pc", dut.dpath.pc_reg, 32'd0);
    check("rst_mid_sw", dut.dpath.dmem.dmem[9], 32'hDEAD_BEEF);
    check("rst_mid_r3", dut.dpath.rbank.regfile[3], 32'd0);

    // 4: GCD(48,18) via beq/bne/slt/sub/j
    clear_imem();
    dut.dpath.dmem.dmem[0] = 32'd48;
    dut.dpath.dmem.dmem[1] = 32'd18;
    dut.dpath.dmem.dmem[2] = 32'd0;
    dut.dpath.imem.imem[0]  = enc_i(6'h23, 5'd0, 5'd1, 16'd0);
    dut.dpath.imem.imem[1]  = enc_i(6'h23, 5'd0, 5'd2, 16'd4);
    dut.dpath.imem.imem[2]  = enc_i(6'h04, 5'd1, 5'd2, 16'd6);
    dut.dpath.imem.imem[3]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A);
    dut.dpath.imem.imem[4]  = enc_i(6'h05, 5'd3, 5'd0, 16'd2);
    dut.dpath.imem.imem[5]  = enc_r(5'd1, 5'd2, 5'd1, 5'd0, 6'h22);
    dut.dpath.imem.imem[6]  = enc_j(26'd2);
    dut.dpath.imem.imem[7]  = enc_r(5'd2, 5'd1, 5'd2, 5'd0, 6'h22);
    dut.dpath.imem.imem[8]  = enc_j(26'd2);
    dut.dpath.imem.imem[9]  = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    dut.dpath.imem.imem[10] = enc_j(26'd10);
    step(2);
    reset = 1'b0;
    step(3);
    check("beq_nottaken", dut.dpath.pc_reg, 32'h0C);
    cyc = 0;
    while (dut.dpath.dmem.dmem[2] !== 32'd6 && cyc < 997) begin
      @(negedge clk);
      cyc++;
    end
    check("gcd_in_time", {31'd0, cyc < 997}, 32'd1);
    check("gcd_result", dut.dpath.dmem.dmem[2], 32'd6);
    step(3);
    check("gcd_spin_pc", dut.dpath.pc_reg, 32'h28);

    // 5: $0 immutability, undefined opcode and funct
    reset = 1'b1;
    clear_imem();
    dut.dpath.imem.imem[0] = enc_i(6'h08, 5'd0, 5'd6, 16'd3);
    dut.dpath.imem.imem[1] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    dut.dpath.imem.imem[2] = enc_r(5'd0, 5'd0, 5'd6, 5'd0, 6'h25);
    dut.dpath.imem.imem[3] = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
    dut.dpath.imem.imem[4] = enc_i(6'h3E, 5'd0, 5'd7, 16'h00AA);
    dut.dpath.imem.imem[5] = enc_r(5'd0, 5'd0, 5'd7, 5'd0, 6'h3F);
    step(2);
    reset = 1'b0;
    step(4);
    check("r0_zero", dut.dpath.rbank.regfile[0], 32'd0);
    check("or_r6", dut.dpath.rbank.regfile[6], 32'd0);
    check("undef_wdata", writedata, 32'd1);
    step(2);
    check("undef_r7", dut.dpath.rbank.regfile[7], 32'd1);
    check("undef_pc", dut.dpath.pc_reg, 32'd24);
    check("dmem_kept", dut.dpath.dmem.dmem[7], 32'd12);

    // 6: opcode 0x3F at PC 0x20
    reset = 1'b1;
    clear_imem();
    dut.dpath.imem.imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    dut.dpath.imem.imem[8] = enc_i(6'h3F, 5'd0, 5'd1, 16'd7);
    step(2);
    reset = 1'b0;
    step(8);
    check("pre_halt_pc", dut.dpath.pc_reg, 32'h20);
    step(1);
`ifdef KGP_RISC_HALT_EN
    check("halt_pc", dut.dpath.pc_reg, 32'h20);
    step(5);
    check("halt_pc_hold", dut.dpath.pc_reg, 32'h20);
`else
    check("nohalt_pc", dut.dpath.pc_reg, 32'h24);
`endif
    check("halt_r1", dut.dpath.rbank.regfile[1], 32'd1);
    check("halt_dmem", dut.dpath.dmem.dmem[2], 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
